// File: rtl/predictor_update_ctrl.sv
// Branch-predictor update controller: queues resolved-branch updates and drains them into the
// counter table, with a table-clear sweep. Define PRED_UPDATE_BYPASS_EN to let an update skip an empty queue.
module predictor_update_ctrl #(
    parameter int LOCAL_WIDTH = 12,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clockIn,
    input  logic                   resetIn,
    input  logic                   readyIn,
    input  logic                   updateValid,
    input  logic [31:0]            updateInstr,
    input  logic                   taken,
    input  logic                   clearReq,
    output logic                   updateFull,
    output logic                   clearBusy,
    output logic                   tableWe,
    output logic [LOCAL_WIDTH-1:0] tableAddr,
    output logic                   tableTaken,
    output logic                   tableClear,
    output logic [7:0]             dropCount
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [LOCAL_WIDTH-1:0] LAST_INDEX = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } stateT;

    stateT                  state;
    logic [LOCAL_WIDTH-1:0] sweepPtr;
    logic [LOCAL_WIDTH-1:0] queueIndex [QUEUE_DEPTH];
    logic                   queueTaken [QUEUE_DEPTH];
    logic [PTR_W-1:0]       headPtr;
    logic [PTR_W-1:0]       tailPtr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       countNext;
    logic [LOCAL_WIDTH-1:0] updateIndex;
    logic                   accept;
    logic                   drop;
    logic                   bypass;
    logic                   push;
    logic                   pop;
    logic                   unusedInstrBits;

    assign updateIndex     = updateInstr[LOCAL_WIDTH+1:2];
    assign unusedInstrBits = ^{updateInstr[31:LOCAL_WIDTH+2], updateInstr[1:0]};

    // Fullness comes from the registered count only, so a pop in the same cycle never frees a slot early.
    assign updateFull = (count == FULL_COUNT);
    assign accept     = readyIn && updateValid && !updateFull;
    assign drop       = readyIn && updateValid && updateFull;
    assign pop        = readyIn && (state == RUN) && !clearReq && (count != '0);

`ifdef PRED_UPDATE_BYPASS_EN
    assign bypass = accept && (state == RUN) && !clearReq && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // Queue storage needs no reset: entries are only ever read behind a valid count.
    always_ff @(posedge clockIn) begin
        if (push) begin
            queueIndex[tailPtr] <= updateIndex;
            queueTaken[tailPtr] <= taken;
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state      <= CLEAR;
            sweepPtr   <= '0;
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            dropCount  <= '0;
            tableWe    <= 1'b0;
            tableAddr  <= '0;
            tableTaken <= 1'b0;
            tableClear <= 1'b0;
            clearBusy  <= 1'b1;
        end else if (!readyIn) begin
            tableWe <= 1'b0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + 1'b1;
            end
            if (pop) begin
                headPtr <= headPtr + 1'b1;
            end
            count <= countNext;
            if (drop && (dropCount != 8'hFF)) begin
                dropCount <= dropCount + 8'd1;
            end

            tableWe    <= 1'b0;
            tableClear <= 1'b0;

            // A clear request always restarts the sweep; the first write of the new sweep comes on the next edge.
            if (clearReq) begin
                state     <= CLEAR;
                sweepPtr  <= '0;
                clearBusy <= 1'b1;
            end else if (state == CLEAR) begin
                tableWe    <= 1'b1;
                tableClear <= 1'b1;
                tableAddr  <= sweepPtr;
                sweepPtr   <= sweepPtr + 1'b1;
                clearBusy  <= 1'b1;
                if (sweepPtr == LAST_INDEX) begin
                    state <= RUN;
                end
            end else begin
                clearBusy <= 1'b0;
                if (pop) begin
                    tableWe    <= 1'b1;
                    tableAddr  <= queueIndex[headPtr];
                    tableTaken <= queueTaken[headPtr];
                end else if (bypass) begin
                    tableWe    <= 1'b1;
                    tableAddr  <= updateIndex;
                    tableTaken <= taken;
                end
            end
        end
    end

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Testbench for predictor_update_ctrl: fixed vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_predictor_update_ctrl;

    localparam int LW = 4;
    localparam int QD = 4;

    logic          clockIn = 1'b0;
    logic          resetIn;
    logic          readyIn;
    logic          updateValid;
    logic [31:0]   updateInstr;
    logic          taken;
    logic          clearReq;
    logic          updateFull;
    logic          clearBusy;
    logic          tableWe;
    logic [LW-1:0] tableAddr;
    logic          tableTaken;
    logic          tableClear;
    logic [7:0]    dropCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        bit tk;
    } entryT;

    typedef struct {
        bit          valid;
        logic [31:0] instr;
        bit          tk;
        bit          expWe;
        int          expAddr;
        bit          expTaken;
    } vecT;

    entryT mQ[$];
    bit    mClearing;
    int    mSweep;
    int    mDrops;
    bit    mBusy;
    bit    eWe;
    bit    eClear;
    bit    eTaken;
    int    eAddr;
    vecT   vecs[8];
    int    idxList[6];

    predictor_update_ctrl #(
        .LOCAL_WIDTH(LW),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clockIn    (clockIn),
        .resetIn    (resetIn),
        .readyIn    (readyIn),
        .updateValid(updateValid),
        .updateInstr(updateInstr),
        .taken      (taken),
        .clearReq   (clearReq),
        .updateFull (updateFull),
        .clearBusy  (clearBusy),
        .tableWe    (tableWe),
        .tableAddr  (tableAddr),
        .tableTaken (tableTaken),
        .tableClear (tableClear),
        .dropCount  (dropCount)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rdy, input bit valid, input logic [31:0] instr,
                                 input bit tk, input bit clr);
        readyIn     = rdy;
        updateValid = valid;
        updateInstr = instr;
        taken       = tk;
        clearReq    = clr;
    endtask

    task automatic modelReset();
        mQ.delete();
        mClearing = 1'b1;
        mSweep    = 0;
        mDrops    = 0;
        mBusy     = 1'b1;
        eWe       = 1'b0;
    endtask

    // Reference behaviour for one rising edge, using the inputs that were stable across it.
    task automatic modelEdge();
        bit    full;
        bit    acc;
        entryT e;
        entryT h;
        if (!readyIn) begin
            eWe = 1'b0;
            return;
        end
        full  = (mQ.size() == QD);
        if (updateValid && full && mDrops < 255) mDrops++;
        acc   = updateValid && !full;
        e.idx = int'(updateInstr[LW+1:2]);
        e.tk  = taken;
        eWe   = 1'b0;
        if (clearReq) begin
            mClearing = 1'b1;
            mSweep    = 0;
            mBusy     = 1'b1;
            if (acc) mQ.push_back(e);
        end else if (mClearing) begin
            eWe    = 1'b1;
            eClear = 1'b1;
            eAddr  = mSweep;
            mSweep++;
            if (mSweep == 2 ** LW) mClearing = 1'b0;
            mBusy = 1'b1;
            if (acc) mQ.push_back(e);
        end else begin
            mBusy = 1'b0;
            if (mQ.size() > 0) begin
                h      = mQ.pop_front();
                eWe    = 1'b1;
                eClear = 1'b0;
                eAddr  = h.idx;
                eTaken = h.tk;
                if (acc) mQ.push_back(e);
            end else if (acc) begin
`ifdef PRED_UPDATE_BYPASS_EN
                eWe    = 1'b1;
                eClear = 1'b0;
                eAddr  = e.idx;
                eTaken = e.tk;
`else
                mQ.push_back(e);
`endif
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".we"}, tableWe, eWe);
        if (eWe) begin
            check({tag, ".addr"}, tableAddr, eAddr);
            check({tag, ".clear"}, tableClear, eClear);
            if (!eClear) check({tag, ".taken"}, tableTaken, eTaken);
        end
        check({tag, ".busy"}, clearBusy, mBusy);
        check({tag, ".full"}, updateFull, (mQ.size() == QD) ? 1 : 0);
        check({tag, ".drop"}, dropCount, mDrops);
    endtask

    task automatic cycle(input string tag);
        @(posedge clockIn);
        #1;
        modelEdge();
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        resetIn = 1'b0;
        #1;
        modelReset();
        check({tag, ".we"}, tableWe, 0);
        check({tag, ".addr"}, tableAddr, 0);
        check({tag, ".taken"}, tableTaken, 0);
        check({tag, ".clear"}, tableClear, 0);
        check({tag, ".full"}, updateFull, 0);
        check({tag, ".busy"}, clearBusy, 1);
        check({tag, ".drop"}, dropCount, 0);
        @(posedge clockIn);
        @(posedge clockIn);
        #3;
        resetIn = 1'b1;
    endtask

    initial begin
        int found;
        int nonClear;
        resetIn = 1'b1;
        applyStimulus(1, 0, 32'h0, 0, 0);
        #2;
        doReset("rst0");

        for (int i = 0; i < 16; i++) begin
            cycle("sweep");
            check("sweep.we", tableWe, 1);
            check("sweep.clear", tableClear, 1);
            check("sweep.addr", tableAddr, i);
            check("sweep.busy", clearBusy, 1);
        end
        cycle("sweepEnd");
        check("sweepEnd.busy", clearBusy, 0);
        check("sweepEnd.we", tableWe, 0);

`ifdef PRED_UPDATE_BYPASS_EN
        vecs[0] = '{1'b1, 32'h14,  1'b1, 1'b1, 5,  1'b1};
        vecs[1] = '{1'b0, 32'h0,   1'b0, 1'b0, 0,  1'b0};
        vecs[2] = '{1'b0, 32'h0,   1'b0, 1'b0, 0,  1'b0};
        vecs[3] = '{1'b1, 32'h08,  1'b0, 1'b1, 2,  1'b0};
        vecs[4] = '{1'b1, 32'h3C,  1'b1, 1'b1, 15, 1'b1};
        vecs[5] = '{1'b1, 32'h104, 1'b1, 1'b1, 1,  1'b1};
        vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b0, 0,  1'b0};
        vecs[7] = '{1'b0, 32'h0,   1'b0, 1'b0, 0,  1'b0};
`else
        vecs[0] = '{1'b1, 32'h14,  1'b1, 1'b0, 0,  1'b0};
        vecs[1] = '{1'b0, 32'h0,   1'b0, 1'b1, 5,  1'b1};
        vecs[2] = '{1'b0, 32'h0,   1'b0, 1'b0, 0,  1'b0};
        vecs[3] = '{1'b1, 32'h08,  1'b0, 1'b0, 0,  1'b0};
        vecs[4] = '{1'b1, 32'h3C,  1'b1, 1'b1, 2,  1'b0};
        vecs[5] = '{1'b1, 32'h104, 1'b1, 1'b1, 15, 1'b1};
        vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b1, 1,  1'b1};
        vecs[7] = '{1'b0, 32'h0,   1'b0, 1'b0, 0,  1'b0};
`endif
        for (int v = 0; v < 8; v++) begin
            applyStimulus(1, vecs[v].valid, vecs[v].instr, vecs[v].tk, 0);
            cycle("vec");
            check($sformatf("vec%0d.we", v), tableWe, vecs[v].expWe);
            if (vecs[v].expWe) begin
                check($sformatf("vec%0d.addr", v), tableAddr, vecs[v].expAddr);
                check($sformatf("vec%0d.taken", v), tableTaken, vecs[v].expTaken);
            end
        end

        // Burst of six updates during a sweep: four fit, two are dropped, then drain with a stall.
        idxList = '{3, 9, 12, 6, 1, 14};
        applyStimulus(1, 0, 32'h0, 0, 1);
        cycle("clrReq");
        check("clrReq.busy", clearBusy, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 32'(idxList[i]) << 2, bit'(i % 2), 0);
            cycle("burst");
        end
        check("burst.full", updateFull, 1);
        check("burst.drop", dropCount, 2);
        applyStimulus(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("sweepRest");
        cycle("drain0");
        check("drain0.we", tableWe, 1);
        check("drain0.clear", tableClear, 0);
        check("drain0.addr", tableAddr, idxList[0]);
        check("drain0.busy", clearBusy, 0);
        applyStimulus(0, 1, 32'h20, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold");
            check("hold.we", tableWe, 0);
            check("hold.drop", dropCount, 2);
            check("hold.full", updateFull, 0);
        end
        applyStimulus(1, 0, 32'h0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            cycle("drain");
            check($sformatf("drain%0d.we", k), tableWe, 1);
            check($sformatf("drain%0d.addr", k), tableAddr, idxList[k]);
            check($sformatf("drain%0d.taken", k), tableTaken, k % 2);
        end
        cycle("drainDone");
        check("drainDone.we", tableWe, 0);

        // Restart the sweep while it is showing entry 7.
        applyStimulus(1, 0, 32'h0, 0, 1);
        cycle("clr2");
        applyStimulus(1, 0, 32'h0, 0, 0);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            cycle("to7");
            if (tableWe && tableAddr == 4'd7) found = 1;
        end
        check("reach7", found, 1);
        applyStimulus(1, 0, 32'h0, 0, 1);
        cycle("restart");
        applyStimulus(1, 0, 32'h0, 0, 0);
        found = 0;
        for (int n = 0; n < 3 && found == 0; n++) begin
            cycle("restartWait");
            if (tableWe) found = 1;
        end
        check("restart.seen", found, 1);
        check("restart.addr", tableAddr, 0);
        check("restart.clear", tableClear, 1);
        for (int i = 1; i < 16; i++) begin
            cycle("resweep");
            check("resweep.we", tableWe, 1);
            check("resweep.addr", tableAddr, i);
        end
        cycle("resweepEnd");
        check("resweepEnd.busy", clearBusy, 0);

        // Reset with three updates queued: none of them may ever reach the table.
        applyStimulus(1, 0, 32'h0, 0, 1);
        cycle("clr3");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 32'(i + 4) << 2, 1, 0);
            cycle("q3");
        end
        applyStimulus(1, 0, 32'h0, 0, 0);
        #2;
        doReset("rstMid");
        nonClear = 0;
        for (int n = 0; n < 24; n++) begin
            cycle("postRst");
            if (tableWe && !tableClear) nonClear++;
        end
        check("postRst.noStale", nonClear, 0);

        // Hold clearReq with a constant stream of updates to drive dropCount into saturation.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1, 1, $urandom, bit'($urandom_range(0, 1)), 1);
            cycle("sat");
        end
        check("sat.drop", dropCount, 255);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 99) < 85, bit'($urandom_range(0, 1)), $urandom,
                          bit'($urandom_range(0, 1)), $urandom_range(0, 99) < 3);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/predictor_update_ctrl.md
PREDICTOR_UPDATE_CTRL -- requirements
Module: predictor_update_ctrl

Interface
REQ-001 SHALL have parameter LOCAL_WIDTH, default 12, meaning log2 of predictor table entries (LOCAL_SIZE = 2**LOCAL_WIDTH).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, meaning update-queue entries (power of two, >=2).
REQ-003 SHALL have port clockIn  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetIn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port readyIn  input  1  global enable; low freezes all state.
REQ-006 SHALL have port updateValid  input  1  resolved-branch update request from Reorder Buffer.
REQ-007 SHALL have port updateInstr  input  32  branch instruction address; index = updateInstr[LOCAL_WIDTH+1:2].
REQ-008 SHALL have port taken  input  1  resolved direction.
REQ-009 SHALL have port clearReq  input  1  request to reinitialise the whole table.
REQ-010 SHALL have port updateFull  output  1  queue full; update not accepted this cycle.
REQ-011 SHALL have port clearBusy  output  1  table sweep in progress; predictions invalid.
REQ-012 SHALL have port tableWe  output  1  table write strobe.
REQ-013 SHALL have port tableAddr  output  LOCAL_WIDTH  table write index.
REQ-014 SHALL have port tableTaken  output  1  direction for counter update.
REQ-015 SHALL have port tableClear  output  1  write init value 2'b01 instead of counter update.
REQ-016 SHALL have port dropCount  output  8  saturating count of updates lost to full queue.

Function
REQ-017 SHALL implement two states: CLEAR (sequential table sweep) and RUN (queue drain).
REQ-018 SHALL accept an update at an enabled edge iff readyIn && updateValid && !updateFull; accepted updates enqueue {index, taken} in arrival order.
REQ-019 SHALL drive updateFull = (count == QUEUE_DEPTH), from registered count only (no same-cycle pop credit).
REQ-020 SHALL, on updateValid && updateFull && readyIn, drop the update and increment dropCount, saturating at 255.
REQ-021 SHALL register all table outputs: in CLEAR each enabled edge loads tableWe=1, tableClear=1, tableAddr=sweep pointer, then increments pointer.
REQ-022 SHALL leave CLEAR for RUN at the edge that loads tableAddr = LOCAL_SIZE-1; clearBusy SHALL be 1 in CLEAR and deassert from the cycle following that edge's write cycle (i.e. after the last write is presented).
REQ-023 SHALL, in RUN with count>0, at each enabled edge pop the head into tableWe=1, tableClear=0, tableAddr, tableTaken; with count==0 load tableWe=0.
REQ-024 SHALL give update latency: accepted in cycle c -> tableWe visible in cycle c+2 (queue not backlogged).
REQ-025 SHALL permit simultaneous push and pop in one edge; count unchanged, order preserved.
REQ-026 SHALL keep accepting updates during CLEAR (until full) and drain them only after CLEAR ends.
REQ-027 SHALL, on clearReq in RUN, enter CLEAR at that edge with pointer 0, queue contents retained; clearReq during CLEAR SHALL restart the sweep at 0.
REQ-028 SHALL, with readyIn low, hold state, pointers, count and dropCount, and load tableWe=0.
REQ-029 SHALL wrap queue head/tail pointers modulo QUEUE_DEPTH.

Reset
REQ-030 SHALL on resetIn low asynchronously set: state CLEAR, sweep pointer 0, queue empty, dropCount 0, tableWe 0, tableAddr 0, tableTaken 0, tableClear 0, updateFull 0, clearBusy 1.
REQ-031 SHALL discard queued updates on reset mid-operation and begin a fresh sweep at the first enabled edge after release.

Configuration
REQ-032 SHALL, with macro PRED_UPDATE_BYPASS_EN defined, in RUN with queue empty, load an accepted update directly into table outputs at its accept edge (latency c+1) without enqueue.
REQ-033 SHALL, without PRED_UPDATE_BYPASS_EN, always enqueue (latency c+2 per REQ-024).

Verification (LOCAL_WIDTH=4, QUEUE_DEPTH=4)
REQ-034 SHALL check reset release: 16 consecutive writes, tableClear=1, tableAddr 0..15, then clearBusy=0, tableWe=0.
REQ-035 SHALL check one update updateInstr=0x0000_0014, taken=1 in cycle c -> tableWe=1, tableAddr=5, tableTaken=1 in cycle c+2 (c+1 with PRED_UPDATE_BYPASS_EN).
REQ-036 SHALL check readyIn low for 3 cycles mid-drain: no writes, no accepts; resumes with identical sequence.
REQ-037 SHALL check 6 back-to-back updates during CLEAR: 4 accepted, updateFull=1, dropCount=2, 4 writes in order after sweep.
REQ-038 SHALL check clearReq at tableAddr=7 of sweep: next write tableAddr=0, full 16-entry sweep follows.
REQ-039 SHALL check resetIn asserted with 3 queued updates: outputs at reset values immediately, queued updates never written.
